// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Holds the load FSM state encoding and default widths.
package instr_mem_loader_pkg;

  localparam int unsigned AddrWidthDef  = 10;
  localparam int unsigned InstrWidthDef = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StData  = 2'd2,
    StDone  = 2'd3
  } load_state_e;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// Single-port synchronous instruction storage.
// Registered read that holds its value between reads; no reset.
module instr_mem_ram #(
  parameter int unsigned addr_width_p  = 10,
  parameter int unsigned instr_width_p = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [addr_width_p-1:0]  addr_i,
  input  logic [instr_width_p-1:0] wdata_i,
  output logic [instr_width_p-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << addr_width_p;

  logic [instr_width_p-1:0] mem_q [Depth];
  logic [instr_width_p-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a packetised load port (base, count, data...)
// and a one-cycle-latency fetch port that only runs while the loader idles.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned addr_width_p  = AddrWidthDef,
  parameter int unsigned instr_width_p = InstrWidthDef
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic                     load_valid_i,
  input  logic [instr_width_p-1:0] load_data_i,
  output logic                     load_ready_o,
  output logic                     load_done_o,
  input  logic                     fetch_en_i,
  input  logic [addr_width_p-1:0]  fetch_addr_i,
  output logic [instr_width_p-1:0] instruction_o,
  output logic                     instr_valid_o
);

  localparam logic [addr_width_p-1:0] CntOne = addr_width_p'(1);

  load_state_e state_q, state_d;

  logic [addr_width_p-1:0]  ptr_q, ptr_d;
  logic [addr_width_p-1:0]  cnt_q, cnt_d;
  logic                     rvalid_q, rvalid_d;
  logic                     rd_seen_q, rd_seen_d;
  logic                     accept;
  logic                     grant;
  logic                     ram_we;
  logic [addr_width_p-1:0]  ram_addr;
  logic [addr_width_p-1:0]  word_lo;
  logic [instr_width_p-1:0] ram_rdata;

  assign word_lo = load_data_i[addr_width_p-1:0];

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCount;
      StCount: if (accept) state_d = (word_lo != '0) ? StData : StDone;
      StData:  if (accept && cnt_q == CntOne) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready is gated by reset so nothing is offered while held in reset.
  always_comb begin
    load_ready_o = reset_n_i && (state_q != StDone);
    load_done_o  = (state_q == StDone);
    accept       = load_valid_i && load_ready_o;
    grant        = fetch_en_i && (state_q == StIdle) && !accept;
    ram_we       = accept && (state_q == StData);
  end

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rvalid_d  = grant;
    rd_seen_d = rd_seen_q | grant;
    if (accept) begin
      unique case (state_q)
        StIdle:  ptr_d = word_lo;
        StCount: cnt_d = word_lo;
        StData: begin
          ptr_d = ptr_q + CntOne;
          cnt_d = cnt_q - CntOne;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  assign ram_addr = ram_we ? ptr_q : fetch_addr_i;

  instr_mem_ram #(
    .addr_width_p  (addr_width_p),
    .instr_width_p (instr_width_p)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (grant),
    .addr_i  (ram_addr),
    .wdata_i (load_data_i),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset; mask it until a fetch lands.
  assign instruction_o = rd_seen_q ? ram_rdata : '0;
  assign instr_valid_o = rvalid_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a fetch scoreboard.
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       reset_n_i;
  logic       load_valid_i;
  logic [7:0] load_data_i;
  logic       load_ready_o;
  logic       load_done_o;
  logic       fetch_en_i;
  logic [3:0] fetch_addr_i;
  logic [7:0] instruction_o;
  logic       instr_valid_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] last_instr;

  instr_mem_loader #(
    .addr_width_p  (4),
    .instr_width_p (8)
  ) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .load_valid_i  (load_valid_i),
    .load_data_i   (load_data_i),
    .load_ready_o  (load_ready_o),
    .load_done_o   (load_done_o),
    .fetch_en_i    (fetch_en_i),
    .fetch_addr_i  (fetch_addr_i),
    .instruction_o (instruction_o),
    .instr_valid_o (instr_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic lv, input logic [7:0] ld,
                     input logic fe, input logic [3:0] fa);
    @(negedge clk);
    load_valid_i = lv;
    load_data_i  = ld;
    fetch_en_i   = fe;
    fetch_addr_i = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [3:0] a);
    logic [7:0] e;
    exp_q.push_back(model[a]);
    cyc(1'b0, 8'h00, 1'b1, a);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(instruction_o), 32'(e));
      last_instr = e;
    end
  endtask

  task automatic send_pkt(input string tag, input logic [3:0] base,
                          input int n, input logic [7:0] d0,
                          input logic [7:0] d1);
    logic [3:0] a;
    cyc(1'b1, {4'h0, base}, 1'b0, 4'h0);
    chk({tag, "_rdy_count"}, 32'(load_ready_o), 32'd1);
    cyc(1'b1, 8'(n), 1'b0, 4'h0);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_done_early"}, 32'(load_done_o), 32'd0);
      cyc(1'b1, (i == 0) ? d0 : d1, 1'b0, 4'h0);
      a = base + 4'(i);
      model[a] = (i == 0) ? d0 : d1;
    end
    chk({tag, "_done"}, 32'(load_done_o), 32'd1);
    chk({tag, "_rdy_done"}, 32'(load_ready_o), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 4'h0);
    chk({tag, "_done_end"}, 32'(load_done_o), 32'd0);
    chk({tag, "_rdy_idle"}, 32'(load_ready_o), 32'd1);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk);
    load_valid_i = 1'b0;
    fetch_en_i   = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    chk({tag, "_instr"}, 32'(instruction_o), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, "_rdy"}, 32'(load_ready_o), 32'd0);
    chk({tag, "_done"}, 32'(load_done_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    chk({tag, "_rdy_after"}, 32'(load_ready_o), 32'd1);
  endtask

  initial begin
    reset_n_i    = 1'b0;
    load_valid_i = 1'b0;
    load_data_i  = 8'h00;
    fetch_en_i   = 1'b0;
    fetch_addr_i = 4'h0;
    last_instr   = 8'h00;
    #1;
    chk("rst_instr", 32'(instruction_o), 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_rdy", 32'(load_ready_o), 32'd0);
    chk("rst_done", 32'(load_done_o), 32'd0);
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    chk("rel_rdy", 32'(load_ready_o), 32'd1);

    send_pkt("pkt1", 4'd3, 2, 8'hA5, 8'h5A);
    fetch("f3", 4'd3);
    fetch("f4", 4'd4);
    cyc(1'b0, 8'h00, 1'b0, 4'h0);
    chk("nofetch_valid", 32'(instr_valid_o), 32'd0);
    chk("nofetch_hold", 32'(instruction_o), 32'(last_instr));

    mid_reset("rst2");
    fetch("f3_kept", 4'd3);

    send_pkt("wrap", 4'd15, 2, 8'h11, 8'h22);
    fetch("f15", 4'd15);
    fetch("f0", 4'd0);

    send_pkt("p5", 4'd5, 1, 8'hC3, 8'h00);
    send_pkt("zero", 4'd5, 0, 8'h00, 8'h00);
    fetch("f5", 4'd5);

    cyc(1'b1, 8'h06, 1'b1, 4'd0);
    chk("ct_base_valid", 32'(instr_valid_o), 32'd0);
    chk("ct_base_hold", 32'(instruction_o), 32'(last_instr));
    cyc(1'b1, 8'h01, 1'b1, 4'd0);
    chk("ct_cnt_valid", 32'(instr_valid_o), 32'd0);
    cyc(1'b1, 8'h99, 1'b1, 4'd0);
    model[6] = 8'h99;
    chk("ct_data_valid", 32'(instr_valid_o), 32'd0);
    chk("ct_done", 32'(load_done_o), 32'd1);
    chk("ct_done_rdy", 32'(load_ready_o), 32'd0);
    cyc(1'b1, 8'hEE, 1'b1, 4'd0);
    chk("ct_dn_valid", 32'(instr_valid_o), 32'd0);
    chk("ct_dn_hold", 32'(instruction_o), 32'(last_instr));
    chk("ct_dn_done", 32'(load_done_o), 32'd0);
    fetch("f6", 4'd6);
    fetch("f0_again", 4'd0);

    cyc(1'b1, 8'h08, 1'b0, 4'h0);
    cyc(1'b1, 8'h03, 1'b0, 4'h0);
    cyc(1'b1, 8'h77, 1'b0, 4'h0);
    model[8] = 8'h77;
    chk("ml_done_pre", 32'(load_done_o), 32'd0);
    mid_reset("rst3");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 4'h0);
      chk("ml_no_done", 32'(load_done_o), 32'd0);
    end
    fetch("f8", 4'd8);
    send_pkt("clean", 4'd9, 1, 8'h44, 8'h00);
    fetch("f9", 4'd9);
    fetch("f8_again", 4'd8);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter addr_width_p, default 10, memory address width; depth = 2**addr_width_p words.
REQ-002 SHALL have parameter instr_width_p, default 16, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_valid_i  input  1  load stream word valid.
REQ-006 SHALL have port load_data_i  input  instr_width_p  load stream word.
REQ-007 SHALL have port load_ready_o  output  1  loader accepts a word this cycle.
REQ-008 SHALL have port load_done_o  output  1  one-cycle pulse at end of each load packet.
REQ-009 SHALL have port fetch_en_i  input  1  fetch request.
REQ-010 SHALL have port fetch_addr_i  input  addr_width_p  fetch address.
REQ-011 SHALL have port instruction_o  output  instr_width_p  fetched instruction, registered.
REQ-012 SHALL have port instr_valid_o  output  1  instruction_o carries fresh fetch data.

Function
REQ-013 A load word SHALL be accepted on a cycle where load_valid_i and load_ready_o are both 1.
REQ-014 The FSM SHALL have states IDLE, COUNT, DATA, DONE.
REQ-015 load_ready_o SHALL be 1 in IDLE, COUNT, DATA; 0 in DONE.
REQ-016 IDLE: an accepted word's low addr_width_p bits SHALL be latched as write pointer; next state COUNT.
REQ-017 COUNT: an accepted word's low addr_width_p bits SHALL be latched as remaining count N; next state DATA if N != 0, else DONE.
REQ-018 DATA: each accepted word SHALL be written to mem[pointer]; pointer increments modulo 2**addr_width_p (wrap from max to 0); N decrements; after the write with N == 1, next state DONE.
REQ-019 DONE: load_done_o SHALL be 1 for exactly this one cycle; next state IDLE unconditionally.
REQ-020 A word offered while load_valid_i is 0 or in DONE SHALL have no effect; FSM holds state while no word is accepted.
REQ-021 A fetch SHALL be granted only in IDLE with no load word accepted that cycle (load wins a simultaneous request).
REQ-022 A granted fetch SHALL drive instruction_o = mem[fetch_addr_i] and instr_valid_o = 1 on the next cycle (latency 1).
REQ-023 An ungranted or absent fetch SHALL give instr_valid_o = 0 next cycle, with instruction_o holding its previous value.
REQ-024 Memory read and write SHALL never coincide (guaranteed by REQ-021), so no read-during-write behaviour is defined.
REQ-025 Memory contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-026 While reset_n_i = 0: FSM = IDLE, pointer = 0, N = 0, instruction_o = 0, instr_valid_o = 0, load_done_o = 0, load_ready_o forced 0.
REQ-027 Reset mid-load SHALL abandon the packet; words already written remain in memory; no load_done_o pulse is produced.
REQ-028 The first cycle after reset_n_i rises SHALL show load_ready_o = 1 (IDLE).

Structure
REQ-029 The FSM state enum and the default instruction width constant SHALL live in the shared definitions package.
REQ-030 Storage SHALL be a sub-module instr_mem_ram: a plain synchronous single-port array with write enable, registered read, and no reset.

Verification (addr_width_p=4, instr_width_p=8)
REQ-031 Reset: assert reset_n_i low mid-cycle -> instruction_o=0x00, instr_valid_o=0, load_ready_o=0 immediately; after release, load_ready_o=1.
REQ-032 Load base 3, count 2, data 0xA5, 0x5A -> load_done_o pulses one cycle after 0x5A is accepted; fetch 3 then fetch 4 -> 0xA5 then 0x5A, each with instr_valid_o=1 one cycle after the request.
REQ-033 Wrap: base 15, count 2, data 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22 on fetch.
REQ-034 Zero count: base 5, count 0 -> DONE directly after COUNT, load_done_o pulses, mem[5] unchanged.
REQ-035 Contention: fetch_en_i=1 in the same cycle as the IDLE base word, and throughout DATA -> instr_valid_o=0, instruction_o holds its last value; load_valid_i held high in DONE -> no word accepted.
REQ-036 Reset mid-load: base 8, count 3, one data word 0x77, then reset -> no load_done_o pulse; after release, fetch 8 -> 0x77; the next packet starts cleanly from IDLE.
